// File: rtl/uart_rx.sv
// 8N1 UART receiver: a 2-flop synchronizer feeds a mid-bit sampling FSM that
// emits single-cycle data_valid / framing_err pulses alongside the held byte.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1302
) (
    input  logic       CLOCK,
    input  logic       clr,
    input  logic       enable,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       data_valid,
    output logic       framing_err,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    logic        rxMeta_q, rxSync_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shiftReg_q, shiftReg_d;
    logic [7:0]  rxData_q, rxData_d;
    logic        dataValid_q, dataValid_d;
    logic        framingErr_q, framingErr_d;
    logic        armed_q, armed_d;

    // Both synchronizer flops reset high so reset never looks like a start edge.
    always_ff @(posedge CLOCK) begin
        if (!clr) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // After a framing error the line must return high (armed) before another
    // start edge is accepted, so a held break yields exactly one error.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shiftReg_d   = shiftReg_q;
        rxData_d     = rxData_q;
        dataValid_d  = 1'b0;
        framingErr_d = 1'b0;
        armed_d      = armed_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (rxSync_q) begin
                    armed_d = 1'b1;
                end
                if (enable && !rxSync_q && armed_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 16'd0;
                    if (!rxSync_q) begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d              = 16'd0;
                    shiftReg_d[idx_q]  = rxSync_q;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                    if (rxSync_q) begin
                        rxData_d    = shiftReg_q;
                        dataValid_d = 1'b1;
                    end else begin
                        framingErr_d = 1'b1;
                        armed_d      = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase

        // Dropping enable aborts silently and keeps the last good byte.
        if (!enable) begin
            state_d      = ST_IDLE;
            cnt_d        = 16'd0;
            idx_d        = 3'd0;
            rxData_d     = rxData_q;
            dataValid_d  = 1'b0;
            framingErr_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!clr) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            idx_q        <= 3'd0;
            shiftReg_q   <= 8'h00;
            rxData_q     <= 8'h00;
            dataValid_q  <= 1'b0;
            framingErr_q <= 1'b0;
            armed_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shiftReg_q   <= shiftReg_d;
            rxData_q     <= rxData_d;
            dataValid_q  <= dataValid_d;
            framingErr_q <= framingErr_d;
            armed_q      <= armed_d;
        end
    end

    assign rx_data     = rxData_q;
    assign data_valid  = dataValid_q;
    assign framing_err = framingErr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected pulses and state probes,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int EXP_LAT = 2 + CPB / 2 + 9 * CPB + 1;

    typedef struct packed {
        logic       isErr;
        logic [7:0] data;
        int         startCycle;
        logic       chkLat;
    } ExpT;

    typedef struct packed {
        logic       isDrain;
        logic       expBusy;
        logic [7:0] expData;
    } ProbeT;

    logic       clock;
    logic       clr;
    logic       enable;
    logic       rx;
    logic [7:0] rxData;
    logic       dataValid;
    logic       framingErr;
    logic       busy;

    int   cycleCnt;
    int   checks;
    int   errors;
    logic [7:0] lastGood;
    ExpT   expQ[$];
    ProbeT probeQ[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK      (clock),
        .clr        (clr),
        .enable     (enable),
        .rx         (rx),
        .rx_data    (rxData),
        .data_valid (dataValid),
        .framing_err(framingErr),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cycleCnt = 0;
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    initial begin
        checks = 0;
        errors = 0;
    end

    // One comparison: tol allows a +/- window around the required value.
    task automatic checkOutput(input string name, input int actual, input int required, input int tol);
        checks++;
        if (actual < required - tol || actual > required + tol) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h (tol %0d) at cycle %0d",
                     name, actual, required, tol, cycleCnt);
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clock) begin
        ExpT   e;
        ProbeT p;
        if (dataValid || framingErr) begin
            if (dataValid && framingErr) begin
                checkOutput("pulseOverlap", 1, 0, 0);
            end
            if (expQ.size() == 0) begin
                checkOutput("unexpectedPulse", int'({dataValid, framingErr}), 0, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("pulseKind", int'(framingErr), int'(e.isErr), 0);
                checkOutput("rxData", int'(rxData), int'(e.data), 0);
                if (e.chkLat) begin
                    checkOutput("latency", cycleCnt - e.startCycle, EXP_LAT, 1);
                end
            end
        end
        if (probeQ.size() != 0) begin
            p = probeQ.pop_front();
            if (p.isDrain) begin
                checkOutput("missingPulse", expQ.size(), 0, 0);
            end else begin
                checkOutput("busy", int'(busy), int'(p.expBusy), 0);
                checkOutput("heldData", int'(rxData), int'(p.expData), 0);
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic probe(input logic expBusy, input logic [7:0] expData);
        ProbeT p;
        p.isDrain = 1'b0;
        p.expBusy = expBusy;
        p.expData = expData;
        probeQ.push_back(p);
    endtask

    // Full frame; the expected pulse is queued before the start bit is driven.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic chkLat);
        ExpT e;
        e.isErr      = !stopBit;
        e.data       = stopBit ? data : lastGood;
        e.startCycle = cycleCnt;
        e.chkLat     = chkLat;
        expQ.push_back(e);
        if (stopBit) lastGood = data;
        rx = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            waitCycles(CPB);
        end
        rx = stopBit;
        waitCycles(CPB);
        rx = 1'b1;
    endtask

    task automatic sendPartial(input logic [7:0] data, input int nBits);
        rx = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < nBits; i++) begin
            rx = data[i];
            waitCycles(CPB);
        end
    endtask

    initial begin
        ProbeT d;
        lastGood = 8'h00;
        clr      = 1'b0;
        enable   = 1'b1;
        rx       = 1'b1;
        waitCycles(3);
        clr = 1'b1;
        waitCycles(2);
        probe(1'b0, 8'h00);
        waitCycles(4);

        applyStimulus(8'hA5, 1'b1, 1'b1);
        waitCycles(2 * CPB);

        // Start glitch: 4 low cycles, rejected at the mid-start sample.
        rx = 1'b0;
        waitCycles(4);
        probe(1'b1, lastGood);
        rx = 1'b1;
        waitCycles(20);
        probe(1'b0, lastGood);
        waitCycles(2 * CPB);

        applyStimulus(8'h3C, 1'b0, 1'b0);
        waitCycles(2 * CPB);

        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        waitCycles(2 * CPB);

        // Reset in the middle of the data bits of 0x55.
        sendPartial(8'h55, 3);
        clr = 1'b0;
        waitCycles(2);
        rx  = 1'b1;
        clr = 1'b1;
        lastGood = 8'h00;
        waitCycles(2);
        probe(1'b0, 8'h00);
        waitCycles(40);
        applyStimulus(8'h81, 1'b1, 1'b0);
        waitCycles(2 * CPB);

        // Enable dropped mid-frame.
        sendPartial(8'h99, 4);
        enable = 1'b0;
        rx     = 1'b1;
        waitCycles(2);
        probe(1'b0, lastGood);
        waitCycles(40);
        enable = 1'b1;
        waitCycles(5);
        applyStimulus(8'h7E, 1'b1, 1'b0);
        waitCycles(2 * CPB);

        // Break: one framing error, no re-trigger while the line stays low.
        begin
            ExpT e;
            e.isErr      = 1'b1;
            e.data       = lastGood;
            e.startCycle = cycleCnt;
            e.chkLat     = 1'b1;
            expQ.push_back(e);
        end
        rx = 1'b0;
        waitCycles(14 * CPB);
        probe(1'b0, lastGood);
        rx = 1'b1;
        waitCycles(2 * CPB);
        applyStimulus(8'h5A, 1'b1, 1'b0);
        waitCycles(20);

        d.isDrain = 1'b1;
        d.expBusy = 1'b0;
        d.expData = 8'h00;
        probeQ.push_back(d);
        waitCycles(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
